instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Upstream stage of the 8-bit CPU. Takes the CPU's even byte address (rom_address),
// reads the two instruction bytes from a byte-wide ROM with variable latency
// (valid-qualified), and presents {opcode1, opcode2} to the CPU over a valid/ready
// handshake. Handles flush, ROM timeout and misaligned addresses.
// PARAMETERS
// ADDR_W   8   ROM/PC address width
// DATA_W   8   ROM data width, also the width of each opcode byte
// TIMEOUT  15  max cycles waiting for rom_rvalid before abandoning a beat (1..255)
// PORTS
// clk          in   1       clock, all logic on posedge
// reset        in   1       synchronous, active-high
// fetch_addr   in   ADDR_W  CPU PC; sampled only in IDLE
// flush        in   1       discard current/in-flight instruction, restart from fetch_addr
// rom_req      out  1       one-cycle ROM read request
// rom_addr     out  ADDR_W  ROM byte address, valid with rom_req
// rom_rvalid   in   1       ROM read data valid (one pulse per request)
// rom_rdata    in   DATA_W  ROM read data
// instr_valid  out  1       opcode1/opcode2 hold a complete instruction
// instr_ready  in   1       CPU accepts instruction (step strobe)
// opcode1      out  DATA_W  byte at addr
// opcode2      out  DATA_W  byte at addr+1
// misalign     out  1       sampled fetch_addr was odd; valid with instr_valid
// fetch_err    out  1       a beat timed out; instruction replaced by NOP
// BEHAVIOUR
// - Reset: state=IDLE; rom_req=0, rom_addr=0, instr_valid=0, opcode1=opcode2=8'h00,
//   misalign=0, fetch_err=0, timeout counter=0. Reset mid-fetch abandons the beat; a
//   late rom_rvalid arriving after reset in IDLE is ignored.
// - States: IDLE, WAIT_LO, REQ_HI, WAIT_HI, HOLD, DRAIN.
// - IDLE: rom_req=1, rom_addr=fetch_addr, addr_q<=fetch_addr, misalign<=fetch_addr[0],
//   fetch_err<=0 -> WAIT_LO.
// - WAIT_LO: on rom_rvalid, opcode1<=rom_rdata -> REQ_HI.
// - REQ_HI: rom_req=1, rom_addr=addr_q+1 (mod 2^ADDR_W, 8'hFF wraps to 8'h00) -> WAIT_HI.
// - WAIT_HI: on rom_rvalid, opcode2<=rom_rdata -> HOLD.
// - HOLD: instr_valid=1; opcode outputs stable until accept. When instr_valid&instr_ready:
//   -> IDLE; next fetch uses fetch_addr sampled in IDLE, one cycle later.
// - Latency with ROM latency L (rvalid L cycles after req): req_lo at T, instr_valid at T+2L+2.
// - Timeout: counter clears on each rom_req, counts in WAIT_LO/WAIT_HI; reaching TIMEOUT
//   without rvalid -> opcode1=opcode2=8'h00 (NOP), fetch_err=1 -> HOLD.
//   rvalid on the same cycle as the timeout expiry is taken as valid data (rvalid wins).
// - Flush in WAIT_LO/WAIT_HI: -> DRAIN (beat outstanding). DRAIN waits for rom_rvalid
//   (data discarded) or timeout, then -> IDLE. Flush in REQ_HI: no request issued,
//   -> IDLE. Flush in HOLD or IDLE: -> IDLE, instr_valid drops next cycle.
// - Flush and accept in the same cycle: both take effect; the instruction counts as
//   consumed; -> IDLE.
// - rom_rvalid in IDLE, REQ_HI or HOLD is spurious and is ignored. At most one ROM
//   request is outstanding at any time.
// - instr_ready while instr_valid=0 has no effect. instr_valid never deasserts without
//   an accept, a flush or reset.
// - Misaligned (odd) address: the fetch still completes normally; misalign is reported.
// STRUCTURE
// - Package cpu_fetch_pkg: fetch_state_e enum, NOP_OPCODE=8'h00, ADDR_W/DATA_W defaults.
//   8'h00 decodes as no-write, no-jump in the controller.
// - Sub-module fetch_timeout_ctr (clear, enable, expired; width $clog2(TIMEOUT+1)).
// - Everything else in one always_ff state machine with a registered output stage;
//   rom_req/rom_addr are decoded from the state.
// TESTING
// - Basic fetch: L=1, ROM[0x10]=0x1A, ROM[0x11]=0x5C, fetch_addr=0x10 -> instr_valid at
//   T+4 with opcode1=0x1A, opcode2=0x5C, misalign=0, fetch_err=0.
// - Backpressure: hold instr_ready=0 for 10 cycles -> outputs stable and no rom_req;
//   pulse ready -> next rom_req exactly 1 cycle later at the new fetch_addr.
// - Wrap: fetch_addr=0xFF -> rom_addr sequence 0xFF then 0x00; misalign=1 with
//   instr_valid.
// - Timeout: ROM never responds to the hi beat, TIMEOUT=15 -> HOLD with
//   opcode1=opcode2=0x00, fetch_err=1, exactly 15 cycles after the hi rom_req.
// - Flush: flush in WAIT_LO with ROM L=3 -> no instr_valid; the late rvalid is
//   discarded; the next request comes after DRAIN at the updated fetch_addr=0x20.
// - Reset: assert reset during WAIT_HI -> next cycle all outputs at reset values; a
//   stray rvalid is ignored; a clean fetch follows.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the CPU instruction fetch stage.
package cpu_fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    // Decodes as no-write, no-jump in the controller.
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLo,
        StReqHi,
        StWaitHi,
        StHold,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// CPU-side and ROM-side signals of the fetch unit; master is the fetch unit itself.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = cpu_fetch_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = cpu_fetch_pkg::DATA_W_DEF
);

    logic [ADDR_W-1:0] fetch_addr;
    logic              flush;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rvalid;
    logic [DATA_W-1:0] rom_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] opcode1;
    logic [DATA_W-1:0] opcode2;
    logic              misalign;
    logic              fetch_err;

    modport master (
        input  fetch_addr, flush, rom_rvalid, rom_rdata, instr_ready,
        output rom_req, rom_addr, instr_valid, opcode1, opcode2, misalign, fetch_err
    );

    modport slave (
        output fetch_addr, flush, rom_rvalid, rom_rdata, instr_ready,
        input  rom_req, rom_addr, instr_valid, opcode1, opcode2, misalign, fetch_err
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for an outstanding ROM beat; expires on the TIMEOUT-th cycle counted
// from the request cycle itself.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Request cycle plus the expiring cycle account for the missing two counts.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt_q >= LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-beat instruction fetch from a byte-wide variable-latency ROM with valid/ready
// hand-off to the CPU, flush, timeout-to-NOP and misalignment reporting.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] opcode1_q;
    logic [DATA_W-1:0] opcode2_q;
    logic              instr_valid_q;
    logic              misalign_q;
    logic              fetch_err_q;

    logic req_lo;
    logic req_hi;
    logic tmo_enable;
    logic tmo_expired;

    // Flush or reset suppresses a request so no second beat is ever outstanding.
    assign req_lo = (state_q == StIdle)  && !reset && !bus.flush;
    assign req_hi = (state_q == StReqHi) && !reset && !bus.flush;

    assign bus.rom_req  = req_lo || req_hi;
    assign bus.rom_addr = req_lo ? bus.fetch_addr :
                          req_hi ? addr_q + ADDR_W'(1) : '0;

    assign tmo_enable = (state_q == StWaitLo) || (state_q == StWaitHi) ||
                        (state_q == StDrain);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.rom_req),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            opcode1_q     <= '0;
            opcode2_q     <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.flush) begin
                        addr_q      <= bus.fetch_addr;
                        misalign_q  <= bus.fetch_addr[0];
                        fetch_err_q <= 1'b0;
                        state_q     <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (bus.flush) begin
                        // Beat already answered or abandoned: nothing left to drain.
                        state_q <= (bus.rom_rvalid || tmo_expired) ? StIdle : StDrain;
                    end else if (bus.rom_rvalid) begin
                        opcode1_q <= bus.rom_rdata;
                        state_q   <= StReqHi;
                    end else if (tmo_expired) begin
                        opcode1_q     <= DATA_W'(NOP_OPCODE);
                        opcode2_q     <= DATA_W'(NOP_OPCODE);
                        fetch_err_q   <= 1'b1;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StReqHi: begin
                    state_q <= bus.flush ? StIdle : StWaitHi;
                end
                StWaitHi: begin
                    if (bus.flush) begin
                        state_q <= (bus.rom_rvalid || tmo_expired) ? StIdle : StDrain;
                    end else if (bus.rom_rvalid) begin
                        opcode2_q     <= bus.rom_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end else if (tmo_expired) begin
                        opcode1_q     <= DATA_W'(NOP_OPCODE);
                        opcode2_q     <= DATA_W'(NOP_OPCODE);
                        fetch_err_q   <= 1'b1;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StHold: begin
                    if (bus.flush || bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                StDrain: begin
                    if (bus.rom_rvalid || tmo_expired) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instr_valid = instr_valid_q;
    assign bus.opcode1     = opcode1_q;
    assign bus.opcode2     = opcode2_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural variable-latency ROM plus an expected-instruction
// queue filled when each fetch is started.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic       mis;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    // ROM model state
    logic [7:0] rom_mem [256];
    int         rom_lat = 1;
    bit         drop_en = 1'b0;
    logic [7:0] drop_addr = 8'h00;
    bit         stray_en = 1'b0;
    bit         pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_data = 8'h00;
    logic [7:0] req_addr_q [$];
    int         req_cyc_q [$];
    exp_t       exp_q [$];

    always @(posedge clk) begin
        #3;
        bus.rom_rvalid = 1'b0;
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                pend           = 1'b0;
                bus.rom_rvalid = 1'b1;
                bus.rom_rdata  = pend_data;
            end
        end
        if (reset === 1'b1) pend = 1'b0;
        if (stray_en) begin
            bus.rom_rvalid = 1'b1;
            bus.rom_rdata  = 8'hEE;
        end
        if (bus.rom_req === 1'b1) begin
            req_addr_q.push_back(bus.rom_addr);
            req_cyc_q.push_back(cyc);
            if (!(drop_en && bus.rom_addr == drop_addr)) begin
                pend      = 1'b1;
                pend_cnt  = rom_lat;
                pend_data = rom_mem[bus.rom_addr];
            end
        end
    end

    function automatic exp_t exp_of(input logic [7:0] a);
        logic [7:0] b;
        b = a + 8'd1;
        return {rom_mem[a], rom_mem[b], a[0], 1'b0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -100;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Called at a #1 point while an instruction is held; returns the accept cycle.
    task automatic start_fetch(input logic [7:0] addr, output int acc);
        bus.fetch_addr  = addr;
        bus.instr_ready = 1'b1;
        acc = cyc;
        step(1);
        bus.instr_ready = 1'b0;
    endtask

    task automatic clear_log();
        req_addr_q.delete();
        req_cyc_q.delete();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        bus.fetch_addr  = 8'h10;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rom_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_rom_req: got %b expected 0", bus.rom_req);
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
        end
        checks++;
        if ({bus.rom_addr, bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err} !== 26'd0)
        begin
            errors++;
            $display("FAIL reset_outputs: addr %h op1 %h op2 %h mis %b err %b expected all 0",
                     bus.rom_addr, bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err);
        end
    endtask

    task automatic test_basic();
        int   t0;
        int   tv;
        exp_t got;
        exp_t exp;
        clear_log();
        rom_lat = 1;
        exp_q.push_back(exp_of(8'h10));
        @(posedge clk);
        #1;
        reset = 1'b0;
        t0 = cyc;
        wait_valid(30, tv);
        checks++;
        if (tv - t0 != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 4", tv - t0);
        end
        checks++;
        if (req_addr_q.size() < 2 || req_addr_q[0] !== 8'h10 || req_addr_q[1] !== 8'h11 ||
            req_cyc_q[0] != t0) begin
            errors++;
            $display("FAIL basic_rom_addr: got %0d reqs %p expected 10,11", req_addr_q.size(),
                     req_addr_q);
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_instr: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_backpressure();
        int         n0;
        int         bad;
        int         acc;
        int         tv;
        logic [7:0] o1;
        logic [7:0] o2;
        exp_t       got;
        exp_t       exp;
        step(1);
        n0  = req_addr_q.size();
        o1  = bus.opcode1;
        o2  = bus.opcode2;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_valid !== 1'b1 || bus.opcode1 !== o1 || bus.opcode2 !== o2) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (req_addr_q.size() != n0) begin
            errors++;
            $display("FAIL bp_no_req: got %0d requests expected 0", req_addr_q.size() - n0);
        end
        step(1);
        clear_log();
        rom_lat = 2;
        exp_q.push_back(exp_of(8'h40));
        start_fetch(8'h40, acc);
        wait_valid(40, tv);
        checks++;
        if (req_cyc_q.size() < 1 || req_cyc_q[0] != acc + 1 || req_addr_q[0] !== 8'h40) begin
            errors++;
            $display("FAIL bp_next_req: got %0d reqs first %p expected addr 40 at cycle %0d",
                     req_cyc_q.size(), req_addr_q, acc + 1);
        end
        checks++;
        if (tv - (acc + 1) != 6) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 6", tv - (acc + 1));
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL bp_instr: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_wrap();
        int   acc;
        int   tv;
        exp_t got;
        exp_t exp;
        step(1);
        clear_log();
        rom_lat = 1;
        exp_q.push_back(exp_of(8'hFF));
        start_fetch(8'hFF, acc);
        wait_valid(30, tv);
        checks++;
        if (req_addr_q.size() != 2 || req_addr_q[0] !== 8'hFF || req_addr_q[1] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_rom_addr: got %p expected ff,00", req_addr_q);
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_instr: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_timeout();
        int   acc;
        int   tv;
        exp_t got;
        exp_t exp;
        step(1);
        clear_log();
        rom_lat   = 1;
        drop_en   = 1'b1;
        drop_addr = 8'h31;
        exp_q.push_back({8'h00, 8'h00, 1'b0, 1'b1});
        start_fetch(8'h30, acc);
        wait_valid(60, tv);
        drop_en = 1'b0;
        checks++;
        if (req_addr_q.size() != 2 || req_addr_q[1] !== 8'h31 || tv - req_cyc_q[1] != 15) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d reqs, hold %0d cycles after hi req, expected 15",
                     req_addr_q.size(), (req_cyc_q.size() > 1) ? tv - req_cyc_q[1] : -1);
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL timeout_instr: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_flush();
        int   acc;
        int   t;
        int   tv;
        exp_t got;
        exp_t exp;
        step(1);
        clear_log();
        rom_lat = 3;
        exp_q.push_back(exp_of(8'h20));
        start_fetch(8'h50, acc);
        t = acc + 1;
        step(1);
        bus.flush      = 1'b1;
        bus.fetch_addr = 8'h20;
        step(1);
        bus.flush = 1'b0;
        wait_valid(60, tv);
        checks++;
        if (req_addr_q.size() < 2 || req_addr_q[0] !== 8'h50 || req_cyc_q[0] != t ||
            req_addr_q[1] !== 8'h20 || req_cyc_q[1] != t + 4) begin
            errors++;
            $display("FAIL flush_reqs: got %p at %p expected 50@%0d 20@%0d", req_addr_q,
                     req_cyc_q, t, t + 4);
        end
        checks++;
        if (tv != t + 12) begin
            errors++;
            $display("FAIL flush_valid_cycle: got %0d expected %0d", tv, t + 12);
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flush_instr: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        int   acc;
        int   t0;
        int   tv;
        int   n;
        exp_t got;
        exp_t exp;
        step(1);
        clear_log();
        rom_lat = 4;
        start_fetch(8'h60, acc);
        step(6);
        reset = 1'b1;
        step(1);
        bus.fetch_addr = 8'h70;
        @(negedge clk);
        checks++;
        if ({bus.rom_req, bus.rom_addr, bus.instr_valid, bus.opcode1, bus.opcode2,
             bus.misalign, bus.fetch_err} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_outputs: req %b addr %h vld %b op1 %h op2 %h expected all 0",
                     bus.rom_req, bus.rom_addr, bus.instr_valid, bus.opcode1, bus.opcode2);
        end
        step(1);
        rom_lat  = 1;
        reset    = 1'b0;
        stray_en = 1'b1;
        t0       = cyc;
        exp_q.push_back(exp_of(8'h70));
        step(1);
        stray_en = 1'b0;
        wait_valid(30, tv);
        n = req_addr_q.size();
        checks++;
        if (n < 2 || req_addr_q[n-2] !== 8'h70 || req_cyc_q[n-2] != t0 ||
            req_addr_q[n-1] !== 8'h71 || tv - t0 != 4) begin
            errors++;
            $display("FAIL midreset_refetch: got reqs %p latency %0d expected 70,71 latency 4",
                     req_addr_q, tv - t0);
        end
        got = {bus.opcode1, bus.opcode2, bus.misalign, bus.fetch_err};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midreset_instr: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i * 37 + 11);
        rom_mem[8'h10] = 8'h1A;
        rom_mem[8'h11] = 8'h5C;
        rom_mem[8'hFF] = 8'hC3;
        rom_mem[8'h00] = 8'h9E;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
